stream_multiplexer: RTL and testbench
=====================================

Name: stream_multiplexer

Overview:
Parametrised registered N:1 multiplexer with valid/ready handshakes on every input channel and on the output. It is the sequential successor to the behavioural 4:1 multiplexer. Two modes are supported:
- Addressed: the channel comes from an address input, as in the combinational mux.
- Round-robin: the block arbitrates fairly among valid channels.
The output stage is a single register. The block sits between multiple producers and one consumer in the datapath.

Parameters:
WIDTH, 8, data bits per channel
CHANNELS, 4, number of input channels (2..16)
SEL_WIDTH, 2, width of addr/out_chan; must equal ceil(log2(CHANNELS))

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  1  0 = addressed, 1 = round-robin
addr  input  SEL_WIDTH  selected channel in addressed mode
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel data valid
in_ready  output  CHANNELS  per-channel accept
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_WIDTH  index of channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: out_valid=0, out_data=0, out_chan=0, round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
- Load enable: load_en = !out_valid | out_ready.
- Grant, addressed mode: grant = addr. No grant if addr >= CHANNELS.
- Grant, round-robin mode: grant is the first i with in_valid[i]=1, searching last+1, last+2, ... with wrap modulo CHANNELS. There is no grant if no channel is valid.
- in_ready[i] = load_en & grant_exists & (grant==i). At most one bit of in_ready is high. in_ready is combinational from mode/addr/in_valid/out_valid/out_ready; no combinational path from in_data.
- Input transfer: in_valid[g] & in_ready[g]. On the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Output transfer without a new input transfer in the same cycle: out_valid <= 0 next edge.
- Simultaneous output and input transfer: the register is reloaded and out_valid stays 1. No bubble.
- Stall: while out_valid & !out_ready, out_data and out_chan are held stable and all in_ready=0.
- Pointer update: the round-robin pointer last <= g only on an input transfer in round-robin mode. Addressed-mode transfers leave the pointer unchanged.
- Mode or addr change: takes effect on the arbitration of the same cycle. The pointer is retained across mode switches. Data in the output register is unaffected.
- Reset mid-operation:
  - any word held in the output register is discarded;
  - in_ready is all 0 during the reset cycle;
  - the pointer returns to CHANNELS-1.
- No input is ever accepted unless its in_valid=1. X on non-selected channels must not propagate to out_data.

Test Plan:
1. Addressed truth table, CHANNELS=4, out_ready=1, non-selected inputs=X. For each addr 0..3, drive the selected channel with 8'h00 then 8'hFF -> out_data matches one cycle later, out_chan=addr, and no X on the output.
2. Round-robin fairness: mode=1, all four in_valid=1 continuously, data = channel index × 8'h11, out_ready=1 -> out_chan sequence 0,1,2,3,0,1… and out_data 00,11,22,33,00 with no idle cycles.
3. Skip and wrap: mode=1, only channels 1 and 3 valid, last=3 after reset -> grants 1,3,1,3. Then only channel 0 valid -> grants 0 every cycle.
4. Backpressure: out_valid=1 holding 8'hA5, out_ready=0 for 3 cycles -> out_data stays A5 and in_ready=0000. When out_ready rises, the new word loads the same cycle A5 is taken, and out_valid stays 1.
5. Invalid address: mode=0, CHANNELS=3, addr=3, all in_valid=1 -> in_ready=000 and out_valid=0 after the register drains.
6. Reset mid-stream: assert reset while out_valid=1 with 8'h5C -> next cycle out_valid=0, out_data=0, out_chan=0. The first round-robin grant after reset is channel 0.

Source files
------------

// File: rtl/stream_multiplexer.sv
// stream_multiplexer: registered N:1 stream multiplexer with valid/ready on
// every input channel and on the output.
//   mode = 0 : addressed, the channel is taken from addr
//   mode = 1 : round-robin, the search starts just after the last granted channel
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   mode, addr           arbitration mode and the addressed channel
//   in_data/in_valid     CHANNELS packed input words and their valids
//   in_ready             per-channel accept (one-hot or zero)
//   out_data/out_chan    registered word and the channel it came from
//   out_valid/out_ready  output handshake
module stream_multiplexer #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_WIDTH-1:0]        addr,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [CHANNELS-1:0]         in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]        out_chan,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [CHANNELS-1:0][WIDTH-1:0] chan_data;
  assign chan_data = in_data;

  logic [WIDTH-1:0]     out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0] out_chan_q,  out_chan_d;
  logic                 out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0] last_q,      last_d;

  logic                 load_en;
  logic                 rr_found;
  logic [SEL_WIDTH-1:0] rr_grant;
  logic [31:0]          addr_ext;
  logic                 addr_ok;
  logic [SEL_WIDTH-1:0] grant;
  logic                 grant_ok;
  logic                 xfer;
  int                   idx;

  // The register can take a word when empty or when its word leaves this cycle.
  assign load_en = !out_valid_q | out_ready;

  // Round-robin search: last+1, last+2, ... wrapping, first valid wins.
  // Wrap is done by a single subtract so non-power-of-two CHANNELS work.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    idx      = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!rr_found && in_valid[SEL_WIDTH'(idx)]) begin
        rr_found = 1'b1;
        rr_grant = SEL_WIDTH'(idx);
      end
    end
  end

  // addr can encode channels that do not exist when CHANNELS < 2**SEL_WIDTH.
  assign addr_ext = 32'(addr);
  assign addr_ok  = addr_ext < 32'(CHANNELS);

  assign grant    = mode ? rr_grant : addr;
  assign grant_ok = mode ? rr_found : addr_ok;

  // in_ready depends only on control inputs and state, never on in_data.
  // Forced low during reset so nothing is consumed from a producer then.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_rdy
    assign in_ready[i] = !reset & load_en & grant_ok & (grant == SEL_WIDTH'(i));
  end

  assign xfer = |(in_ready & in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer) begin
      // Only the granted channel is read, so junk elsewhere never reaches out_data.
      out_data_d  = chan_data[grant];
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (mode) last_d = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SEL_WIDTH'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_multiplexer.sv
module tb_stream_multiplexer;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  addr;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  // 3-channel instance for the unmapped-address case
  logic        mode3;
  logic [1:0]  addr3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_multiplexer #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .addr(addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready));

  stream_multiplexer #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .addr(addr3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_init = 0;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_last;

  // Channel the spec's rules pick right now, -1 when none.
  function automatic int m_grant();
    if (!mode) return (int'(addr) < C) ? int'(addr) : -1;
    for (int k = 1; k <= C; k++) begin
      int ch;
      ch = (m_last + k) % C;
      if (in_valid[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    if (reset || g < 0 || !(!m_valid || out_ready)) return 4'b0;
    return 4'(1 << g);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_init  = 1;
      m_valid = 0;
      m_data  = 8'h00;
      m_chan  = 0;
      m_last  = C - 1;
    end else if (m_init) begin
      int g;
      g = m_grant();
      if ((!m_valid || out_ready) && g >= 0 && in_valid[g]) begin
        m_data  = in_data[g*8 +: 8];
        m_chan  = g;
        m_valid = 1;
        if (mode) m_last = g;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_out_data", 32'(out_data), 32'(m_data));
        chk("model_out_chan", 32'(out_chan), 32'(m_chan));
      end
      chk("model_in_ready", 32'(in_ready), 32'(m_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; mode = 0; addr = 0; in_valid = 0; in_data = 0; out_ready = 1;
    mode3 = 0; addr3 = 0; in_valid3 = 0; in_data3 = 0; out_ready3 = 1;
    repeat (2) step();
    reset = 0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data",  32'(out_data), 0);
    chk("reset_out_chan",  32'(out_chan), 0);

    // Addressed truth table with junk on the other channels
    for (int a = 0; a < 4; a++) begin
      for (int v = 0; v < 2; v++) begin
        step();
        mode = 0;
        addr = 2'(a);
        in_valid = 4'($urandom);
        in_valid[a] = 1'b1;
        in_data = $urandom;
        in_data[a*8 +: 8] = v ? 8'hFF : 8'h00;
        step();
        @(negedge clk);
        chk("addr_data",  32'(out_data), v ? 32'hFF : 32'h00);
        chk("addr_chan",  32'(out_chan), 32'(a));
        chk("addr_valid", 32'(out_valid), 1);
      end
    end

    // Round-robin fairness, all channels valid
    step(); reset = 1; step(); reset = 0;
    mode = 1; in_valid = 4'hF; in_data = 32'h33221100; out_ready = 1;
    for (int n = 0; n < 8; n++) begin
      step();
      @(negedge clk);
      chk("rr_chan",  32'(out_chan), 32'(n % 4));
      chk("rr_data",  32'(out_data), 32'((n % 4) * 8'h11));
      chk("rr_valid", 32'(out_valid), 1);
    end

    // Skip and wrap: channels 1 and 3, then only channel 0
    step(); reset = 1; step(); reset = 0;
    mode = 1; in_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      step();
      if (n == 3) in_valid = 4'b0001;
      @(negedge clk);
      chk("skip_chan", 32'(out_chan), (n % 2) ? 32'd3 : 32'd1);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      @(negedge clk);
      chk("only0_chan",  32'(out_chan), 0);
      chk("only0_valid", 32'(out_valid), 1);
    end

    // Backpressure
    step();
    mode = 0; addr = 2; in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 1;
    step();
    out_ready = 0; in_data[23:16] = 8'h3C;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_data",  32'(out_data), 32'hA5);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("unstall_ready", 32'(in_ready), 32'b0100);
    step();
    @(negedge clk);
    chk("unstall_data",  32'(out_data), 32'h3C);
    chk("unstall_valid", 32'(out_valid), 1);

    // Reset mid-stream
    step();
    addr = 1; in_valid = 4'b0010; in_data[15:8] = 8'h5C; out_ready = 1;
    step();
    out_ready = 0; reset = 1;
    @(negedge clk);
    chk("pre_rst_data",  32'(out_data), 32'h5C);
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("rst_in_ready",  32'(in_ready), 0);
    step();
    reset = 0; mode = 1; in_valid = 4'hF; in_data = 32'h33221100; out_ready = 1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_data",  32'(out_data), 0);
    chk("post_rst_chan",  32'(out_chan), 0);
    step();
    @(negedge clk);
    chk("post_rst_grant", 32'(out_chan), 0);
    chk("post_rst_gdata", 32'(out_data), 0);

    // Unmapped address on the 3-channel instance
    step();
    in_valid = 0;
    mode3 = 0; addr3 = 0; in_valid3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1;
    step();
    addr3 = 3;
    @(negedge clk);
    chk("c3_loaded_valid", 32'(out_valid3), 1);
    chk("c3_loaded_data",  32'(out_data3), 32'h11);
    chk("c3_bad_ready",    32'(in_ready3), 0);
    step();
    @(negedge clk);
    chk("c3_drained",   32'(out_valid3), 0);
    chk("c3_bad_ready2", 32'(in_ready3), 0);
    step();
    @(negedge clk);
    chk("c3_still_empty", 32'(out_valid3), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      mode      = 1'($urandom);
      addr      = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 64) == 0;
    end
    step();
    reset = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
